// File: rtl/ddr3_dq_lane_ctrl.sv
// Per-byte-lane DDR3 DQ controller: serializes write bursts onto the pad cells,
// captures read bursts from them, and inserts one turnaround cycle after every burst.
module ddr3_dq_lane_ctrl #(
  parameter int DQ_W  = 8,
  parameter int BL    = 8,
  parameter int CL    = 5,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [BL*DQ_W-1:0] wr_data,
  input  logic               rd_valid,
  output logic               rd_ready,
  output logic [BL*DQ_W-1:0] rd_data,
  output logic               rd_data_valid,
  output logic [DQ_W-1:0]    pad_a,
  output logic [DQ_W-1:0]    pad_ts,
  output logic [DQ_W-1:0]    pad_ri,
  input  logic [DQ_W-1:0]    pad_z,
  output logic               busy
);

  localparam int W = BL * DQ_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BL - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((CL > 1) ? CL - 2 : 0);

  typedef enum logic [2:0] {
    IDLE, WR_PRE, WR_BURST, RD_WAIT, RD_CAPT, TURN
  } state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   wsh_q, wsh_d;
  logic [W-1:0]   cap_q, cap_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           rdv_q, rdv_d;
  logic           idle_rdy, wr_acc, rd_acc;

  // Ready is gated by reset_n so nothing can handshake while reset is held.
  assign idle_rdy = (state_q == IDLE) && reset_n;
  assign wr_acc   = wr_valid && idle_rdy;
  assign rd_acc   = rd_valid && idle_rdy && !wr_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wsh_d   = wsh_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_acc) begin
          state_d = WR_PRE;
          wsh_d   = wr_data;
        end else if (rd_acc) begin
          state_d = (CL == 1) ? RD_CAPT : RD_WAIT;
        end
      end
      WR_PRE: begin
        state_d = WR_BURST;
        cnt_d   = '0;
      end
      WR_BURST: begin
        wsh_d = wsh_q >> DQ_W;
        if (cnt_q == LAST_BEAT) state_d = TURN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      RD_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = RD_CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_CAPT: begin
        // Beats enter at the top and migrate down, so beat 0 ends at the LSBs.
        cap_d = (cap_q >> DQ_W) | (W'(pad_z) << (W - DQ_W));
        if (cnt_q == LAST_BEAT) begin
          state_d = TURN;
          rdata_d = cap_d;
          rdv_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end

  always_ff @(posedge clk) begin
    wsh_q <= wsh_d;
    cap_q <= cap_d;
  end

  assign wr_ready      = idle_rdy;
  assign rd_ready      = idle_rdy;
  assign busy          = (state_q != IDLE);
  assign pad_ts        = {DQ_W{(state_q == WR_PRE) || (state_q == WR_BURST)}};
  assign pad_a         = (state_q == WR_BURST) ? wsh_q[DQ_W-1:0] : '0;
  assign pad_ri        = {DQ_W{state_q == RD_CAPT}};
  assign rd_data       = rdata_q;
  assign rd_data_valid = rdv_q;

endmodule

// File: tb/tb_ddr3_dq_lane_ctrl.sv
// Bench for ddr3_dq_lane_ctrl: CL=5 and CL=1 instances driven with random bursts,
// compared cycle by cycle against burst-timing expectations computed here.
module tb_ddr3_dq_lane_ctrl;
  localparam int DQ_W = 8;
  localparam int BL   = 8;
  localparam int CL   = 5;
  localparam int W    = BL * DQ_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            wr_valid, rd_valid, wr_ready, rd_ready, rd_data_valid, busy;
  logic [W-1:0]    wr_data, rd_data;
  logic [DQ_W-1:0] pad_a, pad_ts, pad_ri, pad_z;

  logic            wr_valid1, rd_valid1, wr_ready1, rd_ready1, rd_data_valid1, busy1;
  logic [W-1:0]    wr_data1, rd_data1;
  logic [DQ_W-1:0] pad_a1, pad_ts1, pad_ri1, pad_z1;

  ddr3_dq_lane_ctrl #(.DQ_W(DQ_W), .BL(BL), .CL(CL), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .pad_a(pad_a), .pad_ts(pad_ts), .pad_ri(pad_ri), .pad_z(pad_z), .busy(busy));

  ddr3_dq_lane_ctrl #(.DQ_W(DQ_W), .BL(BL), .CL(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_data(wr_data1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1),
    .rd_data_valid(rd_data_valid1),
    .pad_a(pad_a1), .pad_ts(pad_ts1), .pad_ri(pad_ri1), .pad_z(pad_z1), .busy(busy1));

  // Pad model: while RI is high the lane presents successive beats from zbeats.
  logic [DQ_W-1:0] zbeats [BL];
  logic [31:0]     zidx = 0, zidx1 = 0;
  always @(posedge clk) begin
    zidx  <= (pad_ri  != 0) ? zidx  + 1 : 0;
    zidx1 <= (pad_ri1 != 0) ? zidx1 + 1 : 0;
  end
  assign pad_z  = (pad_ri  != 0) ? zbeats[zidx[2:0]]  : '0;
  assign pad_z1 = (pad_ri1 != 0) ? zbeats[zidx1[2:0]] : '0;

  int inv_viol = 0;
  always @(negedge clk) begin
    if (((pad_ts & pad_ri) != 0) || ((pad_ts1 & pad_ri1) != 0) ||
        (pad_ri == 0 && pad_z != 0) || (pad_ri1 == 0 && pad_z1 != 0) ||
        (pad_ts == 0 && pad_a != 0) || (pad_ts1 == 0 && pad_a1 != 0))
      inv_viol <= inv_viol + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_rd, last_rd1;

  function automatic logic [W-1:0] zburst();
    logic [W-1:0] r;
    for (int i = 0; i < BL; i++) r[i*DQ_W +: DQ_W] = zbeats[i];
    return r;
  endfunction

  task automatic load_z(input bit pattern);
    for (int i = 0; i < BL; i++)
      zbeats[i] = pattern ? DQ_W'(8'hA0 + i) : DQ_W'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({wr_ready, rd_ready, busy, rd_data_valid, pad_a, pad_ts, pad_ri} !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b%b busy=%b v=%b a=%h ts=%h ri=%h rd=%h required all 0",
               wr_ready, rd_ready, busy, rd_data_valid, pad_a, pad_ts, pad_ri, rd_data);
    end
    reset_n = 1'b1;
    last_rd = '0; last_rd1 = '0;
    @(negedge clk);
    n_tests++;
    if ({wr_ready, rd_ready, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release_ready: got rdy=%b%b busy=%b required 110", wr_ready, rd_ready, busy);
    end
  endtask

  // Offsets k are cycles after the accepting cycle T.
  task automatic test_write(input logic [W-1:0] d, input bit hold_rd);
    logic [DQ_W-1:0] exp_ts, exp_a;
    @(negedge clk);
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_accept_ready: got %b required 1", wr_ready);
    end
    wr_valid = 1'b1; wr_data = d; rd_valid = hold_rd;
    for (int k = 1; k <= BL + 3; k++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      wr_data  = {$urandom, $urandom};
      exp_ts = (k <= BL + 1) ? '1 : '0;
      exp_a  = (k >= 2 && k <= BL + 1) ? d[(k-2)*DQ_W +: DQ_W] : '0;
      n_tests++;
      if (pad_ts !== exp_ts || pad_a !== exp_a || pad_ri !== '0) begin
        n_fail++;
        $display("FAIL wr_pads k=%0d: got ts=%h a=%h ri=%h required ts=%h a=%h ri=00",
                 k, pad_ts, pad_a, pad_ri, exp_ts, exp_a);
      end
      n_tests++;
      if ({wr_ready, rd_ready, busy, rd_data_valid} !== {k == BL + 3, k == BL + 3, k <= BL + 2, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_ctrl k=%0d: got rdy=%b%b busy=%b v=%b required rdy=%0d busy=%0d v=0",
                 k, wr_ready, rd_ready, busy, rd_data_valid, k == BL + 3, k <= BL + 2);
      end
    end
  endtask

  task automatic test_read(input bit pre_offered);
    logic [W-1:0]    exp;
    logic [DQ_W-1:0] exp_ri;
    exp = zburst();
    if (!pre_offered) @(negedge clk);
    n_tests++;
    if (rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_accept_ready: got %b required 1", rd_ready);
    end
    rd_valid = 1'b1;
    for (int k = 1; k <= CL + BL + 1; k++) begin
      @(negedge clk);
      rd_valid = 1'b0;
      exp_ri = (k >= CL && k <= CL + BL - 1) ? '1 : '0;
      n_tests++;
      if (pad_ri !== exp_ri || pad_ts !== '0 || rd_data_valid !== (k == CL + BL) ||
          rd_ready !== (k == CL + BL + 1)) begin
        n_fail++;
        $display("FAIL rd_ctrl k=%0d: got ri=%h ts=%h v=%b rdy=%b required ri=%h ts=00 v=%0d rdy=%0d",
                 k, pad_ri, pad_ts, rd_data_valid, rd_ready, exp_ri, k == CL + BL, k == CL + BL + 1);
      end
      n_tests++;
      if (rd_data !== ((k >= CL + BL) ? exp : last_rd)) begin
        n_fail++;
        $display("FAIL rd_data k=%0d: got %h required %h", k, rd_data, (k >= CL + BL) ? exp : last_rd);
      end
    end
    last_rd = exp;
  endtask

  task automatic test_cl1();
    logic [W-1:0] exp;
    load_z(1'b0);
    exp = zburst();
    @(negedge clk);
    rd_valid1 = 1'b1;
    for (int k = 1; k <= BL + 2; k++) begin
      @(negedge clk);
      rd_valid1 = 1'b0;
      n_tests++;
      if (pad_ri1 !== ((k <= BL) ? 8'hFF : 8'h00) || rd_data_valid1 !== (k == BL + 1) ||
          rd_ready1 !== (k == BL + 2)) begin
        n_fail++;
        $display("FAIL cl1_ctrl k=%0d: got ri=%h v=%b rdy=%b", k, pad_ri1, rd_data_valid1, rd_ready1);
      end
      n_tests++;
      if (rd_data1 !== ((k >= BL + 1) ? exp : last_rd1)) begin
        n_fail++;
        $display("FAIL cl1_data k=%0d: got %h required %h", k, rd_data1, (k >= BL + 1) ? exp : last_rd1);
      end
    end
    last_rd1 = exp;
  endtask

  task automatic test_reset_mid_read();
    load_z(1'b0);
    @(negedge clk);
    rd_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rd_valid = 1'b0;
    end
    n_tests++;
    if (pad_ri !== 8'hFF) begin
      n_fail++;
      $display("FAIL midrd_capturing: got ri=%h required ff", pad_ri);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, rd_data_valid, rd_ready, pad_a, pad_ts, pad_ri} !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL midrd_reset: got busy=%b v=%b rdy=%b a=%h ts=%h ri=%h rd=%h required all 0",
               busy, rd_data_valid, rd_ready, pad_a, pad_ts, pad_ri, rd_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (rd_data_valid !== 1'b0 || pad_ri !== '0) begin
        n_fail++;
        $display("FAIL midrd_held k=%0d: got v=%b ri=%h required 0", k, rd_data_valid, pad_ri);
      end
    end
    reset_n = 1'b1;
    last_rd = '0; last_rd1 = '0;
    load_z(1'b0);
    test_read(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) test_write({$urandom, $urandom}, 1'b0);
      else begin
        load_z(1'b0);
        test_read(1'b0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0; wr_data = '0;
    wr_valid1 = 1'b0; rd_valid1 = 1'b0; wr_data1 = '0;
    load_z(1'b1);
    test_reset();
    test_write(64'h0706050403020100, 1'b0);
    test_write({$urandom, $urandom}, 1'b0);
    load_z(1'b1);
    test_read(1'b0);
    load_z(1'b0);
    test_read(1'b0);
    load_z(1'b0);
    test_write({$urandom, $urandom}, 1'b1);
    test_read(1'b1);
    test_cl1();
    test_reset_mid_read();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_tests++;
    if (inv_viol !== 0) begin
      n_fail++;
      $display("FAIL pad_invariants: got %0d violating cycles required 0", inv_viol);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_dq_lane_ctrl.md
Name: ddr3_dq_lane_ctrl

Overview:
- Per-byte-lane DQ datapath controller placed directly in front of the SSTL18 DDR3 I/O cells.
- On writes, it serializes a packed burst onto the pad data inputs and drives the tristate enables.
- On reads, it asserts receiver-inhibit release for exactly the burst window, captures the received data, and returns a packed word.
- It enforces a one-cycle bus turnaround between any two bursts, and never drives and receives in the same cycle.

Parameters:
- DQ_W, 8: lane width in bits; one pad cell per bit.
- BL, 8: burst length in beats.
- CL, 5: cycles from read-command accept to first beat on the pads; legal range 1..15.
- CNT_W, 4: width of the beat/latency counter; must hold max(BL, CL).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write burst offered.
- wr_ready  out  1  write burst can be accepted this cycle.
- wr_data  in  BL*DQ_W  packed burst; beat i = wr_data[i*DQ_W +: DQ_W].
- rd_valid  in  1  read command offered.
- rd_ready  out  1  read command can be accepted this cycle.
- rd_data  out  BL*DQ_W  captured burst, same packing as wr_data.
- rd_data_valid  out  1  one-cycle pulse; rd_data is complete.
- pad_a  out  DQ_W  data to pad A inputs.
- pad_ts  out  DQ_W  driver enable to pad TS inputs; all bits equal.
- pad_ri  out  DQ_W  receiver enable to pad RI inputs; all bits equal.
- pad_z  in  DQ_W  received data from pad Z outputs.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; counters clear; rd_data clears to 0.
  - rd_data_valid=0, pad_a=0, pad_ts=0, pad_ri=0, busy=0.
  - A partially captured read is discarded with no rd_data_valid pulse.
  - No handshake completes while reset_n is low.
- States: IDLE, WR_PRE, WR_BURST, RD_WAIT, RD_CAPT, TURN.
- wr_ready and rd_ready are 1 only in IDLE.
- A transfer occurs when valid&ready at a rising edge. If wr_valid and rd_valid are both high in IDLE, the write is accepted and the read waits.
- Write accepted at end of cycle T:
  - wr_data is latched.
  - T+1 (WR_PRE): pad_ts all 1s, pad_a=0 (preamble).
  - T+2..T+1+BL (WR_BURST): pad_ts all 1s, pad_a = beat i in cycle T+2+i.
  - T+2+BL (TURN): pad_ts=0, pad_a=0.
  - T+3+BL: back in IDLE.
- Read accepted at end of cycle T:
  - RD_WAIT lasts CL-1 cycles; it is skipped entirely when CL=1.
  - Cycles T+CL..T+CL+BL-1 (RD_CAPT): pad_ri all 1s. pad_z is sampled at the end of each of these cycles into beat slot i = cycle-(T+CL).
  - T+CL+BL (TURN): pad_ri=0; rd_data_valid=1 for exactly this cycle, with rd_data fully updated.
  - rd_data then holds until the next completed read.
  - T+CL+BL+1: back in IDLE.
- pad_a is 0 whenever pad_ts is 0; pad_ri is 0 outside RD_CAPT.
- Invariant: pad_ts and pad_ri are never both nonzero in the same cycle.
- TURN always lasts exactly 1 cycle and applies after both reads and writes. The minimum gap between the last driven beat and the next accept is therefore 1 idle-bus cycle.
- Beat counter counts 0..BL-1 with no wrap past BL-1; exit is on count==BL-1.
- Inputs wr_data, wr_valid and rd_valid are ignored outside IDLE.

Test Plan:
- Write, DQ_W=8, BL=8, wr_data=0x0706050403020100 accepted at T -> pad_ts=0xFF over T+1..T+9; pad_a=00 at T+1, then 00,01,...,07 at T+2..T+9; pad_ts=0 at T+10; wr_ready=1 at T+11.
- Read, CL=5, with the pad model returning beat i = 0xA0+i when RI is high, accepted at T -> pad_ri=0xFF over T+5..T+12; rd_data=0xA7A6A5A4A3A2A1A0 with rd_data_valid high only at T+13.
- wr_valid and rd_valid both high at T -> write accepted at T; rd_ready=0 over T+1..T+10; read accepted at T+11.
- CL=1 read -> pad_ri high at T+1 through T+8; rd_data_valid at T+9.
- reset_n pulled low at T+7 during a CL=5 read -> all outputs 0 immediately, no rd_data_valid pulse; after release, rd_ready=1 and a fresh read completes normally.
- Throughout all tests, assert (pad_ts & pad_ri)==0 every cycle, and that pad_z is 0 whenever pad_ri is 0.
